// File: rtl/ofmap_writeback.sv
// ofmap_writeback: buffers the post-unit result stream in a show-ahead FIFO
// and drains it to the ofmap SRAM over a valid/ready write port.
// Optional build macro OFMAP_WB_OVF_CNT_EN adds a saturating count of
// results dropped because the FIFO was full; without it ovf_cnt is tied 0.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start
//   RUN   | accepting results for the current layer
//   DRAIN | last result issued, still accepting and emptying the FIFO
//   DONE  | every buffered result committed; waiting for the next start
module ofmap_writeback #(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 22,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_wen,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_total_done,
    output logic              almost_full,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_ready,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic              busy,
    output logic              done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int AF_TH = DEPTH - AF_MARGIN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       occ_q, occ_d;
    logic              af_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];

    logic active, start_ok, full, empty, push_req, push, pop;

    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_ok = start && !active;
    assign full     = (occ_q == (AW+1)'(DEPTH));
    assign empty    = (occ_q == '0);
    assign push_req = in_wen && active;
    // A full FIFO can still take a result if the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign pop      = sram_wen && sram_ready;

    // Head is gated so the write port reads zero whenever nothing is queued.
    assign sram_wen   = !empty;
    assign sram_addr  = empty ? '0 : mem_addr_q[rd_ptr_q];
    assign sram_wdata = empty ? '0 : mem_data_q[rd_ptr_q];

    assign almost_full = af_q;
    assign wr_count    = wr_count_q;
    assign busy        = active;
    assign done        = (state_q == S_DONE);

    // Next occupancy, shared by the counter and the registered almost_full.
    always_comb begin
        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + (AW+1)'(1);
        else if (pop && !push)
            occ_d = occ_q - (AW+1)'(1);
    end

    // Layer sequencing; DRAIN only exits when nothing is queued or arriving.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (in_total_done) state_d = S_DRAIN;
            S_DRAIN: if (empty && !push) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: state, pointers, occupancy, almost_full, write count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            af_q       <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            af_q    <= (occ_d >= (AW+1)'(AF_TH));
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (start_ok)
                wr_count_q <= '0;
            else if (pop)
                wr_count_q <= wr_count_q + CNT_W'(1);
        end
    end

    // FIFO storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_addr_q[wr_ptr_q] <= in_addr;
        end
    end

`ifdef OFMAP_WB_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_q;
    logic             drop;

    assign drop    = push_req && full && !pop;
    assign ovf_cnt = ovf_q;

    // Saturating count of results dropped on a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_q <= '0;
        else if (start_ok)
            ovf_q <= '0;
        else if (drop && (ovf_q != '1))
            ovf_q <= ovf_q + CNT_W'(1);
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_ofmap_writeback.sv
// Scoreboard bench for ofmap_writeback: accepted results are queued when
// driven, and a negedge monitor checks every SRAM write against the queue.
module tb_ofmap_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_wen = 1'b0;
    logic [31:0] in_data = '0;
    logic [21:0] in_addr = '0;
    logic        in_total_done = 1'b0;
    logic        almost_full;
    logic        sram_wen;
    logic [21:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_ready = 1'b0;
    logic [15:0] wr_count;
    logic [15:0] ovf_cnt;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [53:0] exp_q [$];

    logic        stall_prev = 1'b0;
    logic [53:0] stall_head = '0;

`ifdef OFMAP_WB_OVF_CNT_EN
    localparam logic [15:0] EXP_OVF_T2 = 16'd1;
`else
    localparam logic [15:0] EXP_OVF_T2 = 16'd0;
`endif

    ofmap_writeback dut (
        .clk(clk), .rst(rst), .start(start), .in_wen(in_wen),
        .in_data(in_data), .in_addr(in_addr), .in_total_done(in_total_done),
        .almost_full(almost_full), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_ready(sram_ready), .wr_count(wr_count),
        .ovf_cnt(ovf_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each write must match the queue head; stalled heads must hold.
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev && sram_wen)
                chk("stall_hold", {10'd0, sram_addr, sram_wdata}, {10'd0, stall_head});
            if (sram_wen && sram_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {10'd0, sram_addr, sram_wdata}, 64'd0);
                    if (sram_addr == '0 && sram_wdata == '0) begin
                        n_bad++;
                        $display("FAIL unexpected_write: zero write with empty scoreboard");
                    end
                end else begin
                    chk("write", {10'd0, sram_addr, sram_wdata}, {10'd0, exp_q.pop_front()});
                end
            end
            stall_prev = sram_wen && !sram_ready;
            stall_head = {sram_addr, sram_wdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [21:0] a, input logic [31:0] d, input bit accept, input bit last);
        in_wen = 1'b1;
        in_addr = a;
        in_data = d;
        in_total_done = last;
        if (accept) exp_q.push_back({a, d});
        tick();
        in_wen = 1'b0;
        in_total_done = 1'b0;
    endtask

    task automatic total_done_pulse();
        in_total_done = 1'b1;
        tick();
        in_total_done = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit toggle_ready);
        int n = 0;
        while (!done && n < 60) begin
            if (toggle_ready) sram_ready = ~sram_ready;
            tick();
            n++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        // 1: basic flow
        tick();
        chk("rst_wen", sram_wen, 0);
        chk("rst_outs", {almost_full, busy, done, sram_addr, sram_wdata, wr_count, ovf_cnt}, 0);
        rst = 1'b1;
        tick();
        do_start();
        chk("t1_busy", busy, 1);
        sram_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(22'(i), 32'h10 + 32'(i), 1'b1, 1'b0);
            if (i == 0) begin
                chk("t1_lat_wen", sram_wen, 1);
                chk("t1_lat_addr", sram_addr, 0);
            end
        end
        total_done_pulse();
        wait_done("t1_done", 1'b0);
        chk("t1_wr_count", wr_count, 5);
        chk("t1_busy_off", busy, 0);

        // 2: stall, almost_full, drop
        do_start();
        chk("t2_done_clr", done, 0);
        chk("t2_wr_clr", wr_count, 0);
        sram_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(22'h100 + 22'(i), 32'hA0 + 32'(i), 1'b1, 1'b0);
            if (i == 4) chk("t2_af_5", almost_full, 0);
            if (i == 5) chk("t2_af_6", almost_full, 1);
        end
        push(22'h1FF, 32'hDEAD, 1'b0, 1'b0);
        chk("t2_ovf", ovf_cnt, EXP_OVF_T2);
        chk("t2_head", {sram_addr, sram_wdata}, {22'h100, 32'hA0});
        sram_ready = 1'b1;
        total_done_pulse();
        wait_done("t2_done", 1'b0);
        chk("t2_wr_count", wr_count, 8);

        // 3: push on full with simultaneous pop
        do_start();
        chk("t3_ovf_clr", ovf_cnt, 0);
        sram_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(22'h200 + 22'(i), 32'hB0 + 32'(i), 1'b1, 1'b0);
        sram_ready = 1'b1;
        push(22'h2FF, 32'hBEEF, 1'b1, 1'b0);
        chk("t3_af_full", almost_full, 1);
        chk("t3_ovf", ovf_cnt, 0);
        total_done_pulse();
        wait_done("t3_done", 1'b0);
        chk("t3_wr_count", wr_count, 9);

        // 4: total_done with last data, toggling ready
        do_start();
        sram_ready = 1'b1;
        push(22'h1, 32'hA, 1'b1, 1'b0);
        sram_ready = 1'b0;
        push(22'h2, 32'hB, 1'b1, 1'b0);
        sram_ready = 1'b1;
        push(22'h3FFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        chk("t4_drain_busy", busy, 1);
        wait_done("t4_done", 1'b1);
        chk("t4_busy", busy, 0);
        chk("t4_wr_count", wr_count, 3);
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: reset mid-drain
        do_start();
        sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(22'h300 + 22'(i), 32'hC0 + 32'(i), 1'b0, 1'b0);
        total_done_pulse();
        #2 rst = 1'b0;
        #1;
        chk("t5_wen_rst", sram_wen, 0);
        chk("t5_outs_rst", {almost_full, busy, done, wr_count, ovf_cnt}, 0);
        tick();
        rst = 1'b1;
        sram_ready = 1'b1;
        tick();
        chk("t5_idle", {busy, done}, 0);

        // 6: IDLE pushes ignored, then start from DONE
        push(22'h5, 32'h55, 1'b0, 1'b0);
        push(22'h6, 32'h66, 1'b0, 1'b0);
        tick();
        chk("t6_idle_wen", sram_wen, 0);
        chk("t6_idle_cnt", wr_count, 0);
        do_start();
        tick();
        chk("t6_no_stale", sram_wen, 0);
        push(22'h7, 32'h77, 1'b1, 1'b0);
        total_done_pulse();
        wait_done("t6_done", 1'b0);
        chk("t6_wr_count", wr_count, 1);
        do_start();
        chk("t6_restart", {busy, done, wr_count, ovf_cnt}, {1'b1, 1'b0, 16'd0, 16'd0});
        total_done_pulse();
        wait_done("t6_done2", 1'b0);
        tick();
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ofmap_writeback.md
Name: ofmap_writeback

Overview:
Output-side write-back stage directly downstream of the PE top. It consumes the post-unit result stream (enable, 32-bit data, 22-bit address, total_done) and buffers it in a show-ahead FIFO. It drains the FIFO to the ofmap SRAM through a valid/ready write port, so SRAM stalls never lose results. It raises an early almost_full stall and reports layer completion only after every buffered result has been committed.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4
DATA_W, 32, result width
ADDR_W, 22, ofmap address width
AF_MARGIN, 2, almost_full asserts when occupancy is at least DEPTH-AF_MARGIN
CNT_W, 16, width of the committed-write and overflow counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a layer and clears counters
in_wen  in  1  result valid (post-unit write enable)
in_data  in  DATA_W  result data
in_addr  in  ADDR_W  result ofmap address
in_total_done  in  1  pulse; the last result of the layer has been issued
almost_full  out  1  stall request to the controller
sram_wen  out  1  write valid to ofmap SRAM
sram_addr  out  ADDR_W  write address
sram_wdata  out  DATA_W  write data
sram_ready  in  1  SRAM accepts the write this cycle
wr_count  out  CNT_W  writes committed this layer
ovf_cnt  out  CNT_W  dropped results (only with the feature macro; otherwise tied to 0)
busy  out  1  state is RUN or DRAIN
done  out  1  layer fully written; sticky until the next start

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, read/write pointers 0, state IDLE. All outputs are 0: almost_full, sram_wen, sram_addr, sram_wdata, wr_count, ovf_cnt, busy, done.
- Reset asserted mid-operation: pending data is discarded; no SRAM write completes after reset assertion.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on in_total_done.
  - DRAIN -> DONE when the FIFO is empty and no write is pending (sram_wen=0 after the final pop).
  - DONE -> RUN on start.
  - start in RUN or DRAIN is ignored.
- start (from IDLE or DONE) clears wr_count, ovf_cnt and done on the same edge.
- Push: occurs when in_wen=1 and state is RUN or DRAIN.
  - in_wen in IDLE or DONE is ignored and not counted.
- Full handling: a push while full (occupancy==DEPTH) is accepted only if a pop happens on the same edge; otherwise it is dropped.
- Pop: occurs when sram_wen && sram_ready.
  - Pop and push on the same edge leave occupancy unchanged.
- Show-ahead read: sram_wen = !empty. sram_addr and sram_wdata are the FIFO head.
  - Latency: a push into an empty FIFO at edge N gives sram_wen=1 in cycle N+1.
- Handshake: while sram_wen=1 and sram_ready=0, sram_addr and sram_wdata hold stable. sram_wen never deasserts without a pop.
  - Sustained throughput is 1 write per cycle with sram_ready held at 1.
- Ordering: SRAM writes preserve input order; no reordering or coalescing.
- wr_count increments on each pop and wraps modulo 2^CNT_W.
- almost_full is registered: the next-cycle value is (next occupancy >= DEPTH-AF_MARGIN).
- in_total_done and in_wen on the same cycle: the data is pushed and the state moves to DRAIN. Pushes during DRAIN are still accepted.
- in_total_done outside RUN is ignored.
- done is asserted in the cycle after the DRAIN exit condition holds.
- Occupancy counter is log2(DEPTH)+1 bits; pointers wrap at DEPTH.

Optional Feature:
OFMAP_WB_OVF_CNT_EN:
- Defined: every dropped push (full, no simultaneous pop, state RUN/DRAIN) increments ovf_cnt. ovf_cnt saturates at 2^CNT_W-1 and is cleared by start or reset.
- Undefined: ovf_cnt is constant 0 and no counter logic is instantiated. Drop behaviour is identical in both builds.

Test Plan:
1. Reset, start, 5 pushes (addr 0..4, data 0x10..0x14) with sram_ready=1, then in_total_done: SRAM sees 5 in-order writes, each 1 cycle after its push; done=1 follows; wr_count=5.
2. sram_ready=0 and 8 pushes (DEPTH=8): almost_full=1 once occupancy reaches 6. A 9th push is dropped (ovf_cnt=1 with the macro, 0 without). After releasing sram_ready, exactly 8 writes occur and the head data is held stable during the stall.
3. FIFO full and sram_ready=1, push on the same cycle: push accepted, occupancy stays at 8, ovf_cnt=0, no data lost.
4. in_total_done on the same cycle as the last in_wen (addr 0x3FFFFF, data 0xFFFFFFFF) with sram_ready toggling 1/0: the last write lands, then done=1. busy=0 while done=1.
5. Assert rst low mid-drain with 3 entries queued: sram_wen=0 immediately. After release, state is IDLE, all counters 0, and no stale write appears after the next start.
6. Pushes in IDLE, plus a second start in DONE: IDLE pushes are ignored (wr_count=0). start from DONE clears done, wr_count and ovf_cnt and returns the state to RUN.
